// File: rtl/alu_issue.sv
// Decode-and-issue stage ahead of the ALU: RV32 decode into op/a/b plus a
// registered valid/ready slot backed by a one-entry skid buffer.
module alu_issue #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [31:0]           i_instr,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic [DATA_WIDTH-1:0] i_rs1_data,
  input  logic [DATA_WIDTH-1:0] i_rs2_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [7:0]            o_alu_op,
  output logic [DATA_WIDTH-1:0] o_a,
  output logic [DATA_WIDTH-1:0] o_b,
  output logic [4:0]            o_rd,
  output logic                  o_illegal
);

  localparam logic [7:0] OP_ALU_ADD = 8'h00;
  localparam logic [7:0] OP_ALU_SUB = 8'h01;
  localparam logic [7:0] OP_ALU_SLL = 8'h02;
  localparam logic [7:0] OP_ALU_SLT = 8'h03;
  localparam logic [7:0] OP_ALU_XOR = 8'h04;
  localparam logic [7:0] OP_ALU_SRL = 8'h05;
  localparam logic [7:0] OP_ALU_SRA = 8'h06;
  localparam logic [7:0] OP_ALU_OR  = 8'h07;
  localparam logic [7:0] OP_ALU_AND = 8'h08;
  localparam logic [7:0] OP_ALU_MUL = 8'h09;
  localparam logic [7:0] OP_ALU_DIV = 8'h0A;
  localparam logic [7:0] OP_ALU_MOD = 8'h0B;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  logic [7:0]            dec_op;
  logic [DATA_WIDTH-1:0] dec_a;
  logic [DATA_WIDTH-1:0] dec_b;
  logic [4:0]            dec_rd;
  logic                  dec_illegal;

  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] imm_u;
  logic [DATA_WIDTH-1:0] shamt_r;
  logic [DATA_WIDTH-1:0] shamt_i;

  state_e                state_q;
  logic                  valid_q;
  logic                  ready_q;
  logic [7:0]            out_op_q,  skid_op_q;
  logic [DATA_WIDTH-1:0] out_a_q,   skid_a_q;
  logic [DATA_WIDTH-1:0] out_b_q,   skid_b_q;
  logic [4:0]            out_rd_q,  skid_rd_q;
  logic                  out_ill_q, skid_ill_q;

  logic accept;
  logic drain;

  logic unused_rs_fields;
  assign unused_rs_fields = ^i_instr[19:15];

  assign opcode  = i_instr[6:0];
  assign funct3  = i_instr[14:12];
  assign funct7  = i_instr[31:25];
  assign imm_i   = {{(DATA_WIDTH-12){i_instr[31]}}, i_instr[31:20]};
  assign imm_u   = {{(DATA_WIDTH-32){i_instr[31]}}, i_instr[31:12], 12'b0};
  // Shift amounts are always the low five bits, zero-extended.
  assign shamt_r = {{(DATA_WIDTH-5){1'b0}}, i_rs2_data[4:0]};
  assign shamt_i = {{(DATA_WIDTH-5){1'b0}}, i_instr[24:20]};

  always_comb begin
    dec_op      = OP_ALU_ADD;
    dec_a       = '0;
    dec_b       = '0;
    dec_illegal = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        dec_a = i_rs1_data;
        dec_b = i_rs2_data;
        unique case ({funct7, funct3})
          {7'b0000000, 3'b000}: dec_op = OP_ALU_ADD;
          {7'b0000000, 3'b001}: begin dec_op = OP_ALU_SLL; dec_b = shamt_r; end
          {7'b0000000, 3'b010}: dec_op = OP_ALU_SLT;
          {7'b0000000, 3'b100}: dec_op = OP_ALU_XOR;
          {7'b0000000, 3'b101}: begin dec_op = OP_ALU_SRL; dec_b = shamt_r; end
          {7'b0000000, 3'b110}: dec_op = OP_ALU_OR;
          {7'b0000000, 3'b111}: dec_op = OP_ALU_AND;
          {7'b0100000, 3'b000}: dec_op = OP_ALU_SUB;
          {7'b0100000, 3'b101}: begin dec_op = OP_ALU_SRA; dec_b = shamt_r; end
          {7'b0000001, 3'b000}: dec_op = OP_ALU_MUL;
          {7'b0000001, 3'b100}: dec_op = OP_ALU_DIV;
          {7'b0000001, 3'b110}: dec_op = OP_ALU_MOD;
          default:              dec_illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        dec_a = i_rs1_data;
        dec_b = imm_i;
        unique case (funct3)
          3'b000: dec_op = OP_ALU_ADD;
          3'b010: dec_op = OP_ALU_SLT;
          3'b100: dec_op = OP_ALU_XOR;
          3'b110: dec_op = OP_ALU_OR;
          3'b111: dec_op = OP_ALU_AND;
          3'b001: begin
            dec_op      = OP_ALU_SLL;
            dec_b       = shamt_i;
            dec_illegal = (funct7 != 7'b0000000);
          end
          3'b101: begin
            dec_b = shamt_i;
            if (funct7 == 7'b0000000)      dec_op = OP_ALU_SRL;
            else if (funct7 == 7'b0100000) dec_op = OP_ALU_SRA;
            else                           dec_illegal = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec_a = '0;
        dec_b = imm_u;
      end
      OPC_AUIPC: begin
        dec_a = i_pc;
        dec_b = imm_u;
      end
      default: dec_illegal = 1'b1;
    endcase
    // Illegal encodings issue as a harmless ADD of zeros with no destination.
    if (dec_illegal) begin
      dec_op = OP_ALU_ADD;
      dec_a  = '0;
      dec_b  = '0;
    end
  end

  assign dec_rd = dec_illegal ? 5'd0 : i_instr[11:7];

  assign accept = i_valid & ready_q;
  assign drain  = valid_q & i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StEmpty;
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
      out_op_q   <= '0;
      out_a_q    <= '0;
      out_b_q    <= '0;
      out_rd_q   <= '0;
      out_ill_q  <= 1'b0;
      skid_op_q  <= '0;
      skid_a_q   <= '0;
      skid_b_q   <= '0;
      skid_rd_q  <= '0;
      skid_ill_q <= 1'b0;
    end else if (i_flush) begin
      state_q <= StEmpty;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            out_op_q  <= dec_op;
            out_a_q   <= dec_a;
            out_b_q   <= dec_b;
            out_rd_q  <= dec_rd;
            out_ill_q <= dec_illegal;
            valid_q   <= 1'b1;
            state_q   <= StOne;
          end
        end
        StOne: begin
          if (accept && drain) begin
            out_op_q  <= dec_op;
            out_a_q   <= dec_a;
            out_b_q   <= dec_b;
            out_rd_q  <= dec_rd;
            out_ill_q <= dec_illegal;
          end else if (accept) begin
            skid_op_q  <= dec_op;
            skid_a_q   <= dec_a;
            skid_b_q   <= dec_b;
            skid_rd_q  <= dec_rd;
            skid_ill_q <= dec_illegal;
            ready_q    <= 1'b0;
            state_q    <= StFull;
          end else if (drain) begin
            valid_q <= 1'b0;
            state_q <= StEmpty;
          end
        end
        StFull: begin
          if (drain) begin
            out_op_q  <= skid_op_q;
            out_a_q   <= skid_a_q;
            out_b_q   <= skid_b_q;
            out_rd_q  <= skid_rd_q;
            out_ill_q <= skid_ill_q;
            ready_q   <= 1'b1;
            state_q   <= StOne;
          end
        end
        default: begin
          state_q <= StEmpty;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready   = ready_q;
  assign o_valid   = valid_q;
  assign o_alu_op  = out_op_q;
  assign o_a       = out_a_q;
  assign o_b       = out_b_q;
  assign o_rd      = out_rd_q;
  assign o_illegal = out_ill_q;

endmodule
